mdu_iterative: RTL and testbench

MDU_ITERATIVE -- requirements
Module: mdu_iterative

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_div_core.sv | 47 ++++
 rtl/mdu_iterative.sv | 154 +++++++++++++++
 tb/tb_mdu_iterative.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: aluCtrl codes,
// FSM state encoding, datapath width and iteration count.
package mdu_pkg;

    localparam int DATA_W = 32;
    localparam int ITER_N = 32;

    localparam logic [4:0] ALU_MULT  = 5'b01001;
    localparam logic [4:0] ALU_DIV   = 5'b01010;
    localparam logic [4:0] ALU_DIVU  = 5'b01101;
    localparam logic [4:0] ALU_MULTU = 5'b01110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step,
// 32 steps leave quotient and remainder ready for the sign fix-up.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;
    logic              borrow;

    // Trial subtraction is one bit wider than the shifted remainder so the
    // borrow is unambiguous even when the shifted value exceeds 2^32.
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        borrow  = diff[DATA_W+1];
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            quo_q <= {quo_q[DATA_W-2:0], ~borrow};
            rem_q <= borrow ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MIPS-style multiply/divide unit (33 busy cycles per operation).
// Define MDU_DIV_EN to build in the divider; otherwise div/divu are ignored.
module mdu_iterative
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic [4:0]        aluCtrl,
    input  logic              start,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              divZero
);

    mdu_state_e          state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                isMul, isDivOp, isSigned, accept;
    logic [DATA_W-1:0]   magA, magB;
    logic [DATA_W-1:0]   mcand_q;
    logic [2*DATA_W-1:0] acc_q, prod;
    logic [DATA_W:0]     mulSum;
    logic                negRes_q;
    logic [DATA_W-1:0]   hi_q, lo_q, resHi, resLo;
    logic                done_q, divZero_q, resDz;

    always_comb begin
        isMul    = (aluCtrl == ALU_MULT) || (aluCtrl == ALU_MULTU);
        isSigned = (aluCtrl == ALU_MULT) || (aluCtrl == ALU_DIV);
`ifdef MDU_DIV_EN
        isDivOp  = (aluCtrl == ALU_DIV) || (aluCtrl == ALU_DIVU);
`else
        isDivOp  = 1'b0;
`endif
        accept   = start && (state_q == IDLE) && (isMul || isDivOp);
        magA     = (isSigned && opA[DATA_W-1]) ? (~opA + 32'd1) : opA;
        magB     = (isSigned && opB[DATA_W-1]) ? (~opB + 32'd1) : opB;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) state_d = isMul ? MUL : DIV;
            end
            MUL, DIV: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER_N - 1)) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift-add: the carry out of the upper half re-enters as the new MSB.
    assign mulSum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            negRes_q <= 1'b0;
        end else if (accept) begin
            negRes_q <= isSigned && (opA[DATA_W-1] ^ opB[DATA_W-1]);
            if (isMul) begin
                mcand_q <= magA;
                acc_q   <= {32'd0, magB};
            end
        end else if (state_q == MUL) begin
            acc_q <= {mulSum, acc_q[DATA_W-1:1]};
        end
    end

`ifdef MDU_DIV_EN
    logic              isDiv_q, negRem_q, divZ_q;
    logic [DATA_W-1:0] quo, rem;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            isDiv_q  <= 1'b0;
            negRem_q <= 1'b0;
            divZ_q   <= 1'b0;
        end else if (accept) begin
            isDiv_q  <= isDivOp;
            negRem_q <= isSigned && opA[DATA_W-1];
            divZ_q   <= (opB == '0);
        end
    end

    mdu_div_core u_div (
        .clk        (clk),
        .rstN       (rstN),
        .load_i     (accept && isDivOp),
        .step_i     (state_q == DIV),
        .dividend_i (magA),
        .divisor_i  (magB),
        .quotient_o (quo),
        .remainder_o(rem)
    );
`endif

    // Sign fix-up; a zero divisor still yields hi = opA via the remainder path.
    always_comb begin
        prod  = negRes_q ? (~acc_q + 64'd1) : acc_q;
        resHi = prod[2*DATA_W-1:DATA_W];
        resLo = prod[DATA_W-1:0];
        resDz = 1'b0;
`ifdef MDU_DIV_EN
        if (isDiv_q) begin
            resDz = divZ_q;
            resHi = negRem_q ? (~rem + 32'd1) : rem;
            resLo = divZ_q ? '1 : (negRes_q ? (~quo + 32'd1) : quo);
        end
`endif
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            done_q    <= (state_q == FIX);
            divZero_q <= (state_q == FIX) && resDz;
            if (state_q == FIX) begin
                hi_q <= resHi;
                lo_q <= resLo;
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign divZero = divZero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative; a scoreboard queue holds expected
// results from a behavioural model and is drained on every done pulse.
module tb_mdu_iterative;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic [4:0]  aluCtrl;
    logic        start;
    logic [31:0] opA, opB;
    logic        busy, done, divZero;
    logic [31:0] hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } result_t;

    result_t expQ[$];
    int checks   = 0;
    int failures = 0;

    mdu_iterative dut (
        .clk    (clk),
        .rstN   (rstN),
        .aluCtrl(aluCtrl),
        .start  (start),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .divZero(divZero)
    );

    always #5 clk = ~clk;

    function automatic result_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        result_t r;
        longint  p;
        int      sa, sb;
        r  = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            ALU_MULT: begin
                p    = longint'(sa) * longint'(sb);
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            ALU_MULTU: begin
                p    = {32'd0, a} * {32'd0, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            ALU_DIVU: begin
                if (b == 0) begin r.lo = '1; r.hi = a; r.dz = 1'b1; end
                else begin r.lo = a / b; r.hi = a % b; end
            end
            ALU_DIV: begin
                if (b == 0) begin r.lo = '1; r.hi = a; r.dz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.lo = 32'h8000_0000; r.hi = '0; end
                else begin r.lo = 32'(sa / sb); r.hi = 32'(sa % sb); end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit expectAccept);
        aluCtrl = op;
        opA     = a;
        opB     = b;
        start   = 1'b1;
        if (expectAccept) expQ.push_back(model(op, a, b));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle so a back-to-back start can follow.
    task automatic waitDone(input string tag, input int injectAt);
        int      cyc  = 0;
        bit      seen = 0;
        result_t e;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checkOutput({tag, ":busy_c1"}, 64'(busy), 64'd1);
                checkOutput({tag, ":dz_c1"}, 64'(divZero), 64'd0);
            end
            if (cyc == 33) checkOutput({tag, ":busy_c33"}, 64'(busy), 64'd1);
            if (injectAt != 0 && cyc == injectAt) begin
                aluCtrl = ALU_MULTU;
                opA     = 32'h1234_5678;
                opB     = 32'h0000_0010;
                start   = 1'b1;
            end
            if (injectAt != 0 && cyc == injectAt + 1) start = 1'b0;
            if (done) seen = 1;
        end
        checkOutput({tag, ":latency"}, 64'(cyc), 64'd34);
        if (seen) begin
            checkOutput({tag, ":busy_done"}, 64'(busy), 64'd0);
            checkOutput({tag, ":queue"}, 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput({tag, ":hi"}, 64'(hi), 64'(e.hi));
                checkOutput({tag, ":lo"}, 64'(lo), 64'(e.lo));
                checkOutput({tag, ":divZero"}, 64'(divZero), 64'(e.dz));
            end
        end
    endtask

    task automatic expectQuiet(input string tag, input int cycles);
        int doneCnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput({tag, ":no_done"}, 64'(doneCnt), 64'd0);
    endtask

    initial begin
        logic [31:0] holdHi, holdLo;
        rstN    = 1'b0;
        start   = 1'b0;
        aluCtrl = '0;
        opA     = '0;
        opB     = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst:busy", 64'(busy), 64'd0);
        checkOutput("rst:done", 64'(done), 64'd0);
        checkOutput("rst:hi", 64'(hi), 64'd0);
        checkOutput("rst:lo", 64'(lo), 64'd0);
        checkOutput("rst:divZero", 64'(divZero), 64'd0);
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus(5'b00000, 32'd3, 32'd4, 0);
        @(negedge clk);
        checkOutput("nonmdu:busy", 64'(busy), 64'd0);
`ifndef MDU_DIV_EN
        applyStimulus(ALU_DIV, 32'd9, 32'd3, 0);
        @(negedge clk);
        checkOutput("div_off:busy", 64'(busy), 64'd0);
        applyStimulus(ALU_DIVU, 32'd9, 32'd3, 0);
        expectQuiet("divu_off", 40);
        checkOutput("divu_off:busy", 64'(busy), 64'd0);
`endif

        applyStimulus(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        waitDone("multu_max", 0);
        @(negedge clk);
        checkOutput("multu_max:done_width", 64'(done), 64'd0);

        applyStimulus(ALU_MULT, 32'hFFFF_FFFD, 32'd5, 1);
        waitDone("mult_inject", 5);
        holdHi = hi;
        holdLo = lo;
        expectQuiet("mult_inject", 40);
        checkOutput("hold:hi", 64'(hi), 64'(holdHi));
        checkOutput("hold:lo", 64'(lo), 64'(holdLo));

        applyStimulus(ALU_MULT, 32'h8000_0000, 32'h8000_0000, 1);
        waitDone("mult_minmin", 0);
        applyStimulus(ALU_MULTU, 32'hDEAD_BEEF, 32'h0000_0000, 1);
        waitDone("b2b_multu_zero", 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? ALU_MULT : ALU_MULTU, $urandom, $urandom, 1);
            waitDone("b2b_rand_mul", 0);
        end

`ifdef MDU_DIV_EN
        applyStimulus(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 1);
        waitDone("div_neg7_2", 0);
        applyStimulus(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        waitDone("div_ovf", 0);
        applyStimulus(ALU_DIVU, 32'd7, 32'd0, 1);
        waitDone("divu_zero", 0);
        applyStimulus(ALU_DIV, 32'hFFFF_FF00, 32'd0, 1);
        waitDone("div_zero_neg", 0);
        applyStimulus(ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 1);
        waitDone("divu_by1", 0);
        applyStimulus(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 1);
        waitDone("div_pos_neg", 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? ALU_DIV : ALU_DIVU, $urandom, $urandom_range(1, 70000), 1);
            waitDone("b2b_rand_div", 0);
        end
        applyStimulus(ALU_DIVU, 32'd100, 32'd7, 1);
`else
        applyStimulus(ALU_MULTU, 32'd100, 32'd7, 1);
`endif
        repeat (10) @(negedge clk);
        rstN = 1'b0;
        expQ.delete();
        #1;
        checkOutput("abort:busy", 64'(busy), 64'd0);
        checkOutput("abort:hi", 64'(hi), 64'd0);
        checkOutput("abort:lo", 64'(lo), 64'd0);
        checkOutput("abort:done", 64'(done), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        expectQuiet("abort", 40);
        checkOutput("abort:hi_after", 64'(hi), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
